// File: rtl/icetap_capture_ctrl.sv
// Capture sequencer for the icetap logic analyzer: arms on start, stores qualified
// samples around a trigger, records the window addresses and serves chronological readout.
module icetap_capture_ctrl #(
    parameter  int NR_SIGNALS    = 4,
    parameter  int RECORD_DEPTH  = 4,
    localparam int RAM_ADDR_BITS = $clog2(RECORD_DEPTH)
) (
    input  logic                     src_clk,
    input  logic                     src_reset_,
    input  logic                     start,
    input  logic [1:0]               trigger_pos,
    input  logic                     store_hit,
    input  logic                     trigger_hit,
    input  logic [NR_SIGNALS-1:0]    signals_in,
    output logic [1:0]               state,
    output logic [RAM_ADDR_BITS-1:0] start_addr,
    output logic [RAM_ADDR_BITS-1:0] trigger_addr,
    output logic [RAM_ADDR_BITS-1:0] stop_addr,
    output logic                     ram_wr_ena,
    output logic [RAM_ADDR_BITS-1:0] ram_wr_addr,
    output logic [NR_SIGNALS-1:0]    ram_wr_data,
    input  logic                     read_req_first,
    input  logic                     read_req_next,
    output logic                     ram_rd_ena,
    output logic [RAM_ADDR_BITS-1:0] ram_rd_addr
);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_WAIT_TRIGGER = 2'd1,
        S_POST_TRIGGER = 2'd2,
        S_DONE         = 2'd3
    } state_t;

    localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE  = RAM_ADDR_BITS'(1);
    localparam logic [RAM_ADDR_BITS-1:0] ADDR_LAST = RAM_ADDR_BITS'(RECORD_DEPTH - 1);
    localparam logic [RAM_ADDR_BITS-1:0] ADDR_HALF = RAM_ADDR_BITS'(RECORD_DEPTH / 2 - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_wr;
    logic                     w_set_trig;
    logic                     w_enter_done;
    logic                     w_rd_ok;
    logic                     w_wrapped_nxt;
    logic [RAM_ADDR_BITS-1:0] w_post_len;
    logic [RAM_ADDR_BITS-1:0] w_wr_ptr_inc;

    logic [RAM_ADDR_BITS-1:0] r_wr_ptr;
    logic                     r_wrapped;
    logic [RAM_ADDR_BITS-1:0] r_post_cnt;
    logic [RAM_ADDR_BITS-1:0] r_start_addr;
    logic [RAM_ADDR_BITS-1:0] r_trigger_addr;
    logic [RAM_ADDR_BITS-1:0] r_stop_addr;
    logic                     r_wr_ena;
    logic [RAM_ADDR_BITS-1:0] r_wr_addr;
    logic [NR_SIGNALS-1:0]    r_wr_data;
    logic                     r_rd_ena;
    logic [RAM_ADDR_BITS-1:0] r_rd_ptr;

    always_comb begin
        unique case (trigger_pos)
            2'd0:    w_post_len = ADDR_LAST;
            2'd1:    w_post_len = ADDR_HALF;
            default: w_post_len = '0;
        endcase
    end

    assign w_wr_ptr_inc  = r_wr_ptr + ADDR_ONE;
    assign w_wrapped_nxt = r_wrapped | (w_wr && (r_wr_ptr == ADDR_LAST));
    assign w_rd_ok       = !start && (read_req_first || read_req_next) &&
                           (r_state == S_IDLE || r_state == S_DONE);

    always_ff @(posedge src_clk) begin
        if (!src_reset_) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr         = 1'b0;
        w_set_trig   = 1'b0;
        w_enter_done = 1'b0;
        if (start) begin
            w_state_nxt = S_WAIT_TRIGGER;
        end else begin
            unique case (r_state)
                S_WAIT_TRIGGER: begin
                    w_wr = store_hit || trigger_hit;
                    if (trigger_hit) begin
                        w_set_trig = 1'b1;
                        if (r_post_cnt == '0) begin
                            w_enter_done = 1'b1;
                            w_state_nxt  = S_DONE;
                        end else begin
                            w_state_nxt  = S_POST_TRIGGER;
                        end
                    end
                end
                S_POST_TRIGGER: begin
                    w_wr = store_hit;
                    if (store_hit && r_post_cnt == ADDR_ONE) begin
                        w_enter_done = 1'b1;
                        w_state_nxt  = S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge src_clk) begin
        if (!src_reset_) begin
            r_wr_ptr       <= '0;
            r_wrapped      <= 1'b0;
            r_post_cnt     <= '0;
            r_start_addr   <= '0;
            r_trigger_addr <= '0;
            r_stop_addr    <= '0;
            r_wr_ena       <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_rd_ena       <= 1'b0;
            r_rd_ptr       <= '0;
        end else begin
            r_wr_ena <= w_wr;
            if (w_wr) begin
                r_wr_addr <= r_wr_ptr;
                r_wr_data <= signals_in;
            end
            if (start) begin
                r_wr_ptr   <= '0;
                r_wrapped  <= 1'b0;
                r_post_cnt <= w_post_len;
            end else if (w_wr) begin
                r_wr_ptr  <= w_wr_ptr_inc;
                r_wrapped <= w_wrapped_nxt;
                if (r_state == S_POST_TRIGGER) r_post_cnt <= r_post_cnt - ADDR_ONE;
            end
            if (w_set_trig) r_trigger_addr <= r_wr_ptr;
            // Oldest sample follows the stop sample once the ring has been overwritten.
            if (w_enter_done) begin
                r_stop_addr  <= r_wr_ptr;
                r_start_addr <= w_wrapped_nxt ? w_wr_ptr_inc : '0;
            end
            r_rd_ena <= w_rd_ok;
            if (w_rd_ok) r_rd_ptr <= read_req_first ? r_start_addr : r_rd_ptr + ADDR_ONE;
        end
    end

    assign state        = r_state;
    assign start_addr   = r_start_addr;
    assign trigger_addr = r_trigger_addr;
    assign stop_addr    = r_stop_addr;
    assign ram_wr_ena   = r_wr_ena;
    assign ram_wr_addr  = r_wr_addr;
    assign ram_wr_data  = r_wr_data;
    assign ram_rd_ena   = r_rd_ena;
    assign ram_rd_addr  = r_rd_ptr;

endmodule

// File: doc/icetap_capture_ctrl.md
# icetap_capture_ctrl

Capture sequencer for the icetap logic analyzer, in the `src_clk` domain between the scan/config logic and the sample RAM. It takes the already-evaluated store and trigger qualifiers, runs the arm → pre-trigger → post-trigger → done state machine, and generates RAM write addresses and enables. It records the start, trigger and stop addresses, then serves sequential readout of the captured window in chronological order.

## Interface
Parameters:
- `NR_SIGNALS`, 4: width of one sample.
- `RECORD_DEPTH`, 4: RAM depth. Must be a power of two and ≥ 2.
- `RAM_ADDR_BITS`, `$clog2(RECORD_DEPTH)`: localparam.

Ports:
- `src_clk`  in  1  sole clock.
- `src_reset_`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle arm/restart pulse.
- `trigger_pos`  in  2  trigger placement in the window: 0 = start, 1 = middle, 2 or 3 = end. Sampled on `start`.
- `store_hit`  in  1  the current sample qualifies for storage.
- `trigger_hit`  in  1  the current sample is the trigger.
- `signals_in`  in  NR_SIGNALS  sample data.
- `state`  out  2  0 = IDLE, 1 = WAIT_TRIGGER, 2 = POST_TRIGGER, 3 = DONE.
- `start_addr`, `trigger_addr`, `stop_addr`  out  RAM_ADDR_BITS  window addresses. Valid in DONE.
- `ram_wr_ena`  out  1  RAM write strobe.
- `ram_wr_addr`  out  RAM_ADDR_BITS  write address.
- `ram_wr_data`  out  NR_SIGNALS  write data.
- `read_req_first`  in  1  pulse: restart readout at `start_addr`.
- `read_req_next`  in  1  pulse: advance readout by one.
- `ram_rd_ena`  out  1  RAM read strobe.
- `ram_rd_addr`  out  RAM_ADDR_BITS  read address.

## Operation
- Post-trigger count `post_len` is latched on `start`:
  - `trigger_pos`=0 → RECORD_DEPTH-1.
  - `trigger_pos`=1 → RECORD_DEPTH/2-1.
  - `trigger_pos`=2 or 3 → 0.
- `start` from any state (including mid-capture):
  - `wr_ptr`←0, `wrapped`←0, post counter←`post_len`.
  - `state`←WAIT_TRIGGER.
  - Does not write on its own cycle.
- WAIT_TRIGGER:
  - A sample is written when `store_hit` or `trigger_hit` is high. A trigger sample is always stored.
  - Write: data = `signals_in`, addr = `wr_ptr`; then `wr_ptr`←`wr_ptr`+1 mod RECORD_DEPTH. `wrapped`←1 when `wr_ptr` rolls from RECORD_DEPTH-1 to 0.
  - On `trigger_hit`: `trigger_addr`←`wr_ptr`.
    - If `post_len`=0: `stop_addr`←`wr_ptr`, `state`←DONE.
    - Otherwise `state`←POST_TRIGGER.
  - `store_hit` and `trigger_hit` high together produce exactly one write.
- POST_TRIGGER:
  - Each `store_hit` writes one sample and decrements the counter. `trigger_hit` is ignored.
  - The write that takes the counter from 1 to 0 sets `stop_addr`←that address, `state`←DONE.
  - If `wr_ptr` wraps here, `wrapped`←1.
- DONE (and on entry to DONE): `start_addr` = `wrapped` ? (`stop_addr`+1) mod RECORD_DEPTH : 0. No writes. Holds until `start`.
- Readout is honored only in IDLE or DONE; requests in other states are ignored.
  - `read_req_first`: `rd_ptr`←`start_addr`.
  - `read_req_next`: `rd_ptr`←`rd_ptr`+1 mod RECORD_DEPTH. Wraps freely.
  - Both high together: first wins.
  - `start` and a read request in the same cycle: `start` wins, the read is dropped.
- All address arithmetic is modulo RECORD_DEPTH through natural RAM_ADDR_BITS truncation.

## Timing
- Reset values: `state`=0; `start_addr`, `trigger_addr`, `stop_addr`, `ram_wr_addr`, `ram_rd_addr` = 0; `ram_wr_data`=0; `ram_wr_ena`=0; `ram_rd_ena`=0; internal pointers, counters and `wrapped` = 0.
- Reset asserted mid-capture aborts the capture and returns to the reset state on the next edge.
- `ram_wr_ena`, `ram_wr_addr` and `ram_wr_data` are registered: qualifying sample at edge N is presented at the RAM during cycle N+1.
- `state` changes one edge after the causing input.
- A trigger at edge T with `post_len`=P and continuous `store_hit` reaches DONE at edge T+P+1.
- Address outputs update on the same edge as the transition into DONE.
- Read request at edge N → `ram_rd_addr` and `ram_rd_ena`=1 during cycle N+1. RAM data returns at N+2.
- `ram_rd_ena` is high for exactly one cycle per honored request.
- Back-to-back requests are allowed every cycle.

## Test plan
All scenarios use RECORD_DEPTH=4, NR_SIGNALS=4.
- Trigger at start: `trigger_pos`=0, `store_hit`=1, trigger on first sample → writes to addr 0,1,2,3; `trigger_addr`=0, `stop_addr`=3, `start_addr`=0; DONE 4 edges after the trigger edge.
- Trigger at end with wrap: `trigger_pos`=2, `store_hit`=1, trigger on 6th sample → `trigger_addr`=1, `stop_addr`=1, `start_addr`=2, DONE at trigger edge+1.
- Store gating: `trigger_pos`=1, trigger on first sample, `store_hit` low for 3 cycles then high → a single post write at addr 1; `stop_addr`=1, `start_addr`=0; no writes while `store_hit` is low.
- Readout after the wrap case: `read_req_first` then 3× `read_req_next` back-to-back → `ram_rd_addr` 2,3,0,1 with `ram_rd_ena` high for 4 consecutive cycles.
- Restart/reset: `start` during POST_TRIGGER → `state`=1, next write at addr 0, `wrapped` cleared. `src_reset_` low mid-capture → all outputs 0 on the next edge.
- Illegal reads and collisions: `read_req_first` in WAIT_TRIGGER → no `ram_rd_ena`. `start` together with `read_req_next` in DONE → `state`=1, no read issued.
